alu_vec_pipe: RTL and testbench
===============================

ALU_VEC_PIPE -- requirements
Module: alu_vec_pipe

Interface
- REQ-001 SHALL have parameter LANES, default 16: number of vector lanes.
- REQ-002 SHALL have parameter W, default 16: lane width, signed two's-complement fixed point.
- REQ-003 SHALL have parameter FRAC, default 8: fractional bits per lane (Q8.8 at defaults).
- REQ-004 clk  input  1  sole clock; all state updates on rising edge.
- REQ-005 rst_n  input  1  asynchronous, active-low reset.
- REQ-006 in_valid  input  1  operand beat offered.
- REQ-007 in_ready  output  1  operand beat accepted when in_valid and in_ready are both high.
- REQ-008 a  input  LANES*W  operand A; lane 0 = bits [W-1:0].
- REQ-009 b  input  LANES*W  operand B; same lane order.
- REQ-010 opcode  input  3  000 MUL, 010 ADD, 011 SUB, 101 MAC, 110 ACLR; other codes give NOP (result 0, flags Z).
- REQ-011 flag_scalar  input  1  high: b lane 0 is broadcast to every lane.
- REQ-012 out_valid  output  1  result beat present.
- REQ-013 out_ready  input  1  result beat consumed when out_valid and out_ready are both high.
- REQ-014 result  output  LANES*W  per-lane result.
- REQ-015 flags  output  4*LANES  per lane {S,V,N,Z}: saturated, overflow, negative, zero.

Function
- REQ-016 SHALL use a 2-stage pipeline: S1 registers operands, opcode and scalar flag; S2 computes and registers result, flags and accumulator.
- REQ-017 Latency SHALL be 2 cycles from acceptance to out_valid, with a throughput of one beat per cycle when out_ready is held high.
- REQ-018 Stall and advance rules:
  - S2 advances when S2 is empty or out_ready is high.
  - S1 advances when S1 is empty or S2 advances.
  - in_ready = S1 empty or S2 advances.
  - No beat is dropped or duplicated.
- REQ-019 result and flags SHALL be held stable while out_valid is high and out_ready is low.
- REQ-020 ADD/SUB SHALL compute a±b at W+1 bits; V is set when the value does not fit in W bits.
- REQ-021 MUL SHALL compute the 2W-bit signed product, arithmetic-shifted right by FRAC (truncation toward minus infinity); V is set when the shifted value does not fit in W bits.
- REQ-022 Without saturation, the result SHALL be the low W bits of the wide value and S=0.
- REQ-023 MAC SHALL compute, per lane, acc = acc + MUL(a,b) using ADD overflow rules on the sum; result is the new acc; acc updates only when the beat leaves S1 into S2.
- REQ-024 ACLR SHALL set every acc lane to 0, return result 0 and flags Z.
- REQ-025 For every op: Z = (result==0); N = result MSB; flags SHALL be computed on the final (possibly saturated) result.
- REQ-026 Back-to-back MAC beats SHALL chain correctly, with each beat seeing the acc written by the previous beat.

Reset
- REQ-027 While rst_n is low:
  - S1 and S2 valid bits are 0; out_valid=0; in_ready=0.
  - result=0; flags=0; acc=0.
- REQ-028 Reset asserted mid-operation SHALL discard in-flight beats with no output.
- REQ-029 in_ready SHALL go high on the first clock edge after rst_n deasserts.

Configuration
- REQ-030 Macro ALU_VEC_PIPE_SAT_EN:
  - Defined: an overflowing lane clamps to max positive or min negative by the sign of the wide value, with S=1; MAC acc stores the clamped value.
  - Undefined: wrap per REQ-022, S always 0, no saturation logic.

Structure
- REQ-031 Package alu_vec_pkg SHALL hold the opcode enum (op_e), the flag bit index constants and the default LANES/W/FRAC localparams.
- REQ-032 Sub-module alu_lane SHALL implement one combinational lane (op, a, b, acc_in -> res, flags, acc_out), instantiated LANES times by generate.

Verification
- REQ-033 MUL vector, lane 0 a=0x0140, b=0xFE80 -> lane 0 result 0xFE20, flags N=1 after 2 cycles.
- REQ-034 ADD scalar, a lanes {0x0180, 0x0140}, b lane0=0x0200 -> results {0x0380, 0x0340}.
- REQ-035 ADD a=0x7F00, b=0x0200: without SAT_EN -> 0x8100 with V=1, S=0; with SAT_EN -> 0x7FFF with V=1, S=1.
- REQ-036 ACLR, then three MAC beats each a=b=0x0100 back-to-back -> results 0x0100, 0x0200, 0x0300.
- REQ-037 out_ready held low 5 cycles with in_valid high -> in_ready drops after 2 beats accepted, result held stable; release -> beats emerge in order, none lost.
- REQ-038 rst_n pulsed low with 2 beats in flight -> out_valid=0, acc=0; following MUL behaves as in REQ-033.

Source files
------------

// File: rtl/alu_vec_pkg.sv
// alu_vec_pkg: opcode encoding, per-lane flag bit positions and default vector geometry
// shared by alu_vec_pipe and alu_lane.
package alu_vec_pkg;

   localparam int LANES_DEF = 16;
   localparam int W_DEF     = 16;
   localparam int FRAC_DEF  = 8;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_S = 3;

   typedef enum logic [2:0] {
      OP_MUL  = 3'b000,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_MAC  = 3'b101,
      OP_ACLR = 3'b110
   } op_e;

endpackage

// File: rtl/alu_lane.sv
// alu_lane: one combinational fixed-point lane (MUL/ADD/SUB/MAC/ACLR, NOP otherwise).
// Define ALU_VEC_PIPE_SAT_EN to clamp overflowing results instead of wrapping.
module alu_lane
   import alu_vec_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  op_e                 op,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] acc_in,
   output logic [W-1:0]        res,
   output logic [3:0]          flags,
   output logic [W-1:0]        acc_out
);

   // Two guard bits beyond the full product so the MAC sum can never wrap internally.
   localparam int WW = 2*W + 2;

   logic signed [WW-1:0] a_x;
   logic signed [WW-1:0] b_x;
   logic signed [WW-1:0] acc_x;
   logic signed [WW-1:0] prod;
   logic signed [WW-1:0] prod_sh;
   logic signed [WW-1:0] wide;
   logic                 fits;
   logic                 ovf;
   logic                 sat;

   assign a_x     = WW'(a);
   assign b_x     = WW'(b);
   assign acc_x   = WW'(acc_in);
   assign prod    = a_x * b_x;
   assign prod_sh = prod >>> FRAC;

   always_comb begin
      wide = '0;
      case (op)
         OP_MUL:  wide = prod_sh;
         OP_ADD:  wide = a_x + b_x;
         OP_SUB:  wide = a_x - b_x;
         OP_MAC:  wide = acc_x + prod_sh;
         default: wide = '0;
      endcase
   end

   assign fits = (wide[WW-1:W-1] == {(WW-W+1){wide[W-1]}});
   assign ovf  = !fits;

`ifdef ALU_VEC_PIPE_SAT_EN
   localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   always_comb begin
      sat = ovf;
      res = wide[W-1:0];
      if (ovf) begin
         res = wide[WW-1] ? MIN_NEG : MAX_POS;
      end
   end
`else
   assign sat = 1'b0;
   assign res = wide[W-1:0];
`endif

   always_comb begin
      acc_out = acc_in;
      case (op)
         OP_MAC:  acc_out = res;
         OP_ACLR: acc_out = '0;
         default: acc_out = acc_in;
      endcase
   end

   assign flags[FLAG_S] = sat;
   assign flags[FLAG_V] = ovf;
   assign flags[FLAG_N] = res[W-1];
   assign flags[FLAG_Z] = (res == '0);

endmodule

// File: rtl/alu_vec_pipe.sv
// alu_vec_pipe: two-stage valid/ready vector fixed-point ALU with per-lane accumulator.
// Define ALU_VEC_PIPE_SAT_EN to enable saturation in every lane.
module alu_vec_pipe
   import alu_vec_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = W_DEF,
   parameter int FRAC  = FRAC_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   a,
   input  logic [LANES*W-1:0]   b,
   input  logic [2:0]           opcode,
   input  logic                 flag_scalar,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   result,
   output logic [4*LANES-1:0]   flags
);

   logic                 s1_valid;
   logic                 s2_valid;
   logic                 ready_en;
   logic                 s1_scalar;
   logic [2:0]           s1_op;
   op_e                  s1_op_e;
   logic [LANES*W-1:0]   s1_a;
   logic [LANES*W-1:0]   s1_b;
   logic [LANES*W-1:0]   acc;
   logic [LANES*W-1:0]   lane_res;
   logic [LANES*W-1:0]   lane_acc;
   logic [4*LANES-1:0]   lane_flags;
   logic                 s2_adv;
   logic                 s1_adv;
   logic                 accept;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   // ready_en keeps in_ready low through reset and the first edge after it.
   assign in_ready  = ready_en && s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign s1_op_e   = op_e'(s1_op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en  <= 1'b0;
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_op     <= '0;
         s1_scalar <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (s1_adv) begin
            s1_valid <= accept;
         end
         if (accept) begin
            s1_a      <= a;
            s1_b      <= b;
            s1_op     <= opcode;
            s1_scalar <= flag_scalar;
         end
      end
   end

   // acc moves only together with a beat entering S2, so back-to-back MACs chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         result   <= '0;
         flags    <= '0;
         acc      <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result <= lane_res;
            flags  <= lane_flags;
            acc    <= lane_acc;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [W-1:0] b_lane;

      assign b_lane = s1_scalar ? s1_b[W-1:0] : s1_b[i*W +: W];

      alu_lane #(
         .W    (W),
         .FRAC (FRAC)
      ) u_lane (
         .op      (s1_op_e),
         .a       (s1_a[i*W +: W]),
         .b       (b_lane),
         .acc_in  (acc[i*W +: W]),
         .res     (lane_res[i*W +: W]),
         .flags   (lane_flags[4*i +: 4]),
         .acc_out (lane_acc[i*W +: W])
      );
   end

endmodule

// File: tb/tb_alu_vec_pipe.sv
// tb_alu_vec_pipe: directed literal checks plus randomized traffic against an
// integer-arithmetic lane model with a per-lane accumulator and expected-output queue.
module tb_alu_vec_pipe;
   import alu_vec_pkg::*;

   localparam int LANES = 16;
   localparam int W     = 16;
   localparam int FRAC  = 8;
   localparam int LW    = LANES*W;

`ifdef ALU_VEC_PIPE_SAT_EN
   localparam logic [15:0] OVF_RES = 16'h7FFF;
   localparam logic [3:0]  OVF_FLG = 4'b1100;
`else
   localparam logic [15:0] OVF_RES = 16'h8100;
   localparam logic [3:0]  OVF_FLG = 4'b0110;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [LW-1:0]     a = '0;
   logic [LW-1:0]     b = '0;
   logic [2:0]        opcode = 3'b000;
   logic              flag_scalar = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [LW-1:0]     result;
   logic [4*LANES-1:0] flags;

   int vectors = 0;
   int miscompares = 0;
   int n_out = 0;
   int n_acc = 0;

   typedef struct {
      logic [LW-1:0]      r;
      logic [4*LANES-1:0] f;
   } exp_t;

   exp_t               q[$];
   logic [LW-1:0]      out_log[$];
   logic [4*LANES-1:0] flg_log[$];
   longint             macc[LANES];

   always #5 clk = ~clk;

   alu_vec_pipe #(.LANES(LANES), .W(W), .FRAC(FRAC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .opcode      (opcode),
      .flag_scalar (flag_scalar),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .flags       (flags)
   );

   function automatic longint lane_val(input logic [LW-1:0] v, input int i);
      logic signed [W-1:0] t;
      t = v[i*W +: W];
      return longint'(t);
   endfunction

   function automatic exp_t model(input logic [2:0] op, input logic [LW-1:0] av,
                                  input logic [LW-1:0] bv, input logic sc);
      exp_t   e;
      longint lo;
      longint hi;
      e.r = '0;
      e.f = '0;
      lo  = -(longint'(1) << (W-1));
      hi  = (longint'(1) << (W-1)) - 1;
      for (int i = 0; i < LANES; i++) begin
         longint       x;
         longint       y;
         longint       v;
         bit           ov;
         bit           st;
         logic [W-1:0] r;
         x = lane_val(av, i);
         y = lane_val(bv, sc ? 0 : i);
         case (op)
            3'b000:  v = (x * y) >>> FRAC;
            3'b010:  v = x + y;
            3'b011:  v = x - y;
            3'b101:  v = macc[i] + ((x * y) >>> FRAC);
            default: v = 0;
         endcase
         ov = (v < lo) || (v > hi);
         st = 1'b0;
         r  = v[W-1:0];
`ifdef ALU_VEC_PIPE_SAT_EN
         if (ov) begin
            st = 1'b1;
            r  = (v < 0) ? lo[W-1:0] : hi[W-1:0];
         end
`endif
         if (op == 3'b101) macc[i] = lane_val(LW'(r), 0);
         if (op == 3'b110) macc[i] = 0;
         e.r[i*W +: W]  = r;
         e.f[4*i +: 4]  = {st, ov, r[W-1], (r == '0)};
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Single compare process: reset state while rst_n low, otherwise the queue head.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         for (int i = 0; i < LANES; i++) macc[i] = 0;
         vectors++;
         if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== '0 || flags !== '0) begin
            miscompares++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b result=%h flags=%h",
                     out_valid, in_ready, result, flags);
         end
      end else begin
         if (out_valid) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_out: result=%h with no beat expected", result);
            end else begin
               if (result !== q[0].r || flags !== q[0].f) begin
                  miscompares++;
                  $display("FAIL out_beat: got %h/%h expected %h/%h",
                           result, flags, q[0].r, q[0].f);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  out_log.push_back(result);
                  flg_log.push_back(flags);
                  n_out++;
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(opcode, a, b, flag_scalar));
            n_acc++;
         end
      end
   end

   task automatic drive(input logic [2:0] op, input logic [LW-1:0] av,
                        input logic [LW-1:0] bv, input logic sc);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      opcode = op; a = av; b = bv; flag_scalar = sc; in_valid = 1'b1;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_out(input int tgt);
      int n;
      n = 0;
      while (n_out < tgt && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n_out < tgt) chk("output_timeout", 64'(n_out), 64'(tgt));
   endtask

   function automatic logic [LW-1:0] rand_vec();
      logic [LW-1:0] v;
      for (int i = 0; i < LANES; i++) begin
         logic [W-1:0] l;
         if ($urandom_range(0, 1) == 1) l = W'($urandom);
         else l = W'($urandom_range(0, 2047)) - W'(1024);
         v[i*W +: W] = l;
      end
      return v;
   endfunction

   initial begin
      logic [LW-1:0]      av;
      logic [LW-1:0]      bv;
      logic [4*LANES-1:0] zflags;
      int                 base;
      int                 acc_seen;
      int                 n;

      for (int i = 0; i < LANES; i++) zflags[4*i +: 4] = 4'b0001;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 chk("in_ready_after_edge", 64'(in_ready), 64'd1);
      out_ready = 1'b1;

      // MUL with latency: beat offered, accepted at next edge, out_valid one edge later.
      av = '0; bv = '0;
      av[15:0] = 16'h0140; bv[15:0] = 16'hFE80;
      opcode = 3'b000; a = av; b = bv; flag_scalar = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("mul_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("mul_latency_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("mul_latency_valid", 64'(out_valid), 64'd1);
      chk("mul_res", 64'(result[15:0]), 64'h FE20);
      chk("mul_flags", 64'(flags[3:0]), 64'b0010);
      wait_out(1);

      // ADD with scalar broadcast; lane 1 of b is junk that must be ignored.
      base = out_log.size();
      av = '0; bv = '0;
      av[15:0] = 16'h0180; av[31:16] = 16'h0140; bv[15:0] = 16'h0200; bv[31:16] = 16'h1234;
      drive(3'b010, av, bv, 1'b1);
      wait_out(base + 1);
      if (out_log.size() > base) begin
         chk("add_sc_l0", 64'(out_log[base][15:0]), 64'h0380);
         chk("add_sc_l1", 64'(out_log[base][31:16]), 64'h0340);
         chk("add_sc_l5", 64'(out_log[base][95:80]), 64'h0200);
      end

      // ADD overflow at the positive edge.
      base = out_log.size();
      av = '0; bv = '0;
      av[15:0] = 16'h7F00; bv[15:0] = 16'h0200;
      drive(3'b010, av, bv, 1'b0);
      wait_out(base + 1);
      if (out_log.size() > base) begin
         chk("add_ovf_res", 64'(out_log[base][15:0]), 64'(OVF_RES));
         chk("add_ovf_flags", 64'(flg_log[base][3:0]), 64'(OVF_FLG));
      end

      // SUB going negative.
      base = out_log.size();
      av = '0; bv = '0;
      av[15:0] = 16'h0100; bv[15:0] = 16'h0300;
      drive(3'b011, av, bv, 1'b0);
      wait_out(base + 1);
      if (out_log.size() > base) begin
         chk("sub_res", 64'(out_log[base][15:0]), 64'hFE00);
         chk("sub_flags", 64'(flg_log[base][3:0]), 64'b0010);
      end

      // ACLR then three chained MACs.
      base = out_log.size();
      av = '0; bv = '0;
      for (int i = 0; i < LANES; i++) begin
         av[i*W +: W] = 16'h0100; bv[i*W +: W] = 16'h0100;
      end
      drive(3'b110, av, bv, 1'b0);
      drive(3'b101, av, bv, 1'b0);
      drive(3'b101, av, bv, 1'b0);
      drive(3'b101, av, bv, 1'b0);
      wait_out(base + 4);
      if (out_log.size() > base + 3) begin
         chk("aclr_flags", 64'(flg_log[base]), 64'(zflags));
         chk("mac1", 64'(out_log[base+1][15:0]), 64'h0100);
         chk("mac2", 64'(out_log[base+2][15:0]), 64'h0200);
         chk("mac3", 64'(out_log[base+3][255:240]), 64'h0300);
      end

      // Undefined opcode acts as NOP.
      base = out_log.size();
      drive(3'b111, rand_vec(), rand_vec(), 1'b0);
      wait_out(base + 1);
      if (out_log.size() > base) begin
         chk("nop_res", 64'(out_log[base] == '0), 64'd1);
         chk("nop_flags", 64'(flg_log[base]), 64'(zflags));
      end

      // Backpressure: only two beats fit with the output stalled.
      base = n_out;
      out_ready = 1'b0;
      n = n_acc;
      acc_seen = n_acc;
      opcode = 3'b010; a = rand_vec(); b = rand_vec(); flag_scalar = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         if (n_acc != acc_seen) begin
            acc_seen = n_acc;
            a = rand_vec();
         end
      end
      chk("bp_accepted", 64'(n_acc - n), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_out(base + 2);
      chk("bp_drained", 64'(q.size()), 64'd0);

      // Reset with two MAC beats in flight.
      out_ready = 1'b0;
      drive(3'b101, av, bv, 1'b0);
      drive(3'b101, av, bv, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b1;
      base = out_log.size();
      drive(3'b101, av, bv, 1'b0);
      wait_out(n_out + 1);
      if (out_log.size() > base) chk("mac_after_reset", 64'(out_log[base][15:0]), 64'h0100);
      base = out_log.size();
      av = '0; bv = '0;
      av[15:0] = 16'h0140; bv[15:0] = 16'hFE80;
      drive(3'b000, av, bv, 1'b0);
      wait_out(n_out + 1);
      if (out_log.size() > base) chk("mul_after_reset", 64'(out_log[base][15:0]), 64'hFE20);

      // Randomized traffic with random backpressure.
      acc_seen = n_acc;
      for (int c = 0; c < 3000; c++) begin
         if (!in_valid || n_acc != acc_seen) begin
            acc_seen = n_acc;
            in_valid = ($urandom_range(0, 9) < 7);
            if (in_valid) begin
               opcode = 3'($urandom_range(0, 7));
               a = rand_vec();
               b = rand_vec();
               flag_scalar = ($urandom_range(0, 3) == 0);
            end
         end
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("final_drain", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
